spike_axi_bridge: RTL and testbench

- Synthesizable successor to the DPI-driven AXI agent: converts a simple single-request bus (Spike/core side) into single-beat AXI transactions on the CPUNC fabric.
- Parametrised data width (32/64) with byte-lane steering, concurrent AW/W issue, error responses and an optional watchdog.

---
 rtl/spike_axi_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_spike_axi_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_axi_bridge.sv
// spike_axi_bridge: single-request core bus to single-beat AXI bridge.
// One transaction outstanding at a time; sub-word accesses are steered onto
// the correct byte lanes on the way out and right-aligned on the way back.
// Optional wait-state watchdog: define SPIKE_AXI_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CHK   | size/alignment check of the latched request
// AR    | read address issued, waiting for ARREADY
// R     | waiting for read data
// WR    | AW and W issued together, each retired on its own handshake
// B     | waiting for write response
// RSP   | one-cycle response pulse to the core
module spike_axi_bridge #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 12,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  CPUNC_ACLK,
   input  logic                  CPUNC_ARESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [1:0]            req_size,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_W-1:0]     CPUNC_AWADDR,
   output logic                  CPUNC_AWVALID,
   input  logic                  CPUNC_AWREADY,
   output logic [DATA_W-1:0]     CPUNC_WDATA,
   output logic [DATA_W/8-1:0]   CPUNC_WSTRB,
   output logic                  CPUNC_WLAST,
   output logic                  CPUNC_WVALID,
   input  logic                  CPUNC_WREADY,
   input  logic [1:0]            CPUNC_BRESP,
   input  logic                  CPUNC_BVALID,
   output logic                  CPUNC_BREADY,
   output logic [ADDR_W-1:0]     CPUNC_ARADDR,
   output logic                  CPUNC_ARVALID,
   input  logic                  CPUNC_ARREADY,
   input  logic [DATA_W-1:0]     CPUNC_RDATA,
   input  logic [1:0]            CPUNC_RRESP,
   input  logic                  CPUNC_RVALID,
   output logic                  CPUNC_RREADY
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYC < 1) begin : g_param_err
      $error("spike_axi_bridge: DATA_W must be 32 or 64 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CHK, S_AR, S_R, S_WR, S_B, S_RSP
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_req_ready;
   logic                 r_write;
   logic [ADDR_W-1:0]    r_addr;
   logic [1:0]           r_size;
   logic [DATA_W-1:0]    r_wdata;
   logic                 r_aw_done;
   logic                 r_w_done;
   logic                 r_err;
   logic [DATA_W-1:0]    r_rdata;

   logic                 w_accept;
   logic                 w_chk_err;
   logic                 w_tmo;
   logic                 w_tmo_hit;
   logic                 w_awvalid;
   logic                 w_wvalid;
   logic [3:0]           w_nbytes;
   logic [OFF_W-1:0]     w_off;
   logic [STRB_W-1:0]    w_bmask;
   logic [DATA_W-1:0]    w_dmask;
   logic [DATA_W-1:0]    w_rdata_al;
   logic [ADDR_W-1:0]    w_addr_al;

   assign w_nbytes  = 4'd1 << r_size;
   assign w_off     = r_addr[OFF_W-1:0];
   assign w_addr_al = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign w_chk_err = (w_nbytes > 4'(STRB_W)) ||
                      ((r_addr[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0);
   assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;

   // byte-lane mask for the access size, right-aligned
   always_comb begin
      w_bmask = '0;
      w_dmask = '0;
      for (int i = 0; i < STRB_W; i++) begin
         w_bmask[i]       = (i < int'(w_nbytes));
         w_dmask[8*i +: 8] = {8{w_bmask[i]}};
      end
   end

   assign w_rdata_al = (CPUNC_RDATA >> {w_off, 3'b000}) & w_dmask;

`ifdef SPIKE_AXI_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo_cnt;

   // watchdog down-counter, reloaded on every state change
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
      if (CPUNC_ARESET) begin
         r_tmo_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
      end else if (r_tmo_cnt != '0) begin
         r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
   end

   assign w_tmo = (r_tmo_cnt == '0);
`else
   assign w_tmo = 1'b0;
`endif

   // state register
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
      if (CPUNC_ARESET) r_state <= S_IDLE;
      else              r_state <= w_state_nxt;
   end

   // next-state decode; a watchdog expiry only wins when no handshake completes
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_hit   = 1'b0;
      w_awvalid   = (r_state == S_WR) && !r_aw_done;
      w_wvalid    = (r_state == S_WR) && !r_w_done;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_CHK;
         S_CHK:  w_state_nxt = w_chk_err ? S_RSP : (r_write ? S_WR : S_AR);
         S_AR: begin
            if (CPUNC_ARREADY)  w_state_nxt = S_R;
            else if (w_tmo) begin w_state_nxt = S_RSP; w_tmo_hit = 1'b1; end
         end
         S_R: begin
            if (CPUNC_RVALID)   w_state_nxt = S_RSP;
            else if (w_tmo) begin w_state_nxt = S_RSP; w_tmo_hit = 1'b1; end
         end
         S_WR: begin
            if (r_aw_done && r_w_done) w_state_nxt = S_B;
            else if (w_tmo) begin w_state_nxt = S_RSP; w_tmo_hit = 1'b1; end
         end
         S_B: begin
            if (CPUNC_BVALID)   w_state_nxt = S_RSP;
            else if (w_tmo) begin w_state_nxt = S_RSP; w_tmo_hit = 1'b1; end
         end
         S_RSP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // request capture, handshake tracking and response formation
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
      if (CPUNC_ARESET) begin
         r_req_ready <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_size      <= '0;
         r_wdata     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_req_ready <= (w_state_nxt == S_IDLE);
         if (w_accept) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_size    <= req_size;
            r_wdata   <= req_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
         end
         if (w_awvalid && CPUNC_AWREADY) r_aw_done <= 1'b1;
         if (w_wvalid && CPUNC_WREADY)   r_w_done  <= 1'b1;
         if (r_state == S_CHK && w_chk_err) r_err <= 1'b1;
         if (r_state == S_R && CPUNC_RVALID) begin
            r_err   <= (CPUNC_RRESP != 2'b00);
            r_rdata <= (CPUNC_RRESP == 2'b00) ? w_rdata_al : '0;
         end
         if (r_state == S_B && CPUNC_BVALID) r_err <= (CPUNC_BRESP != 2'b00);
         if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
         end
      end
   end

   assign req_ready     = r_req_ready;
   assign rsp_valid     = (r_state == S_RSP);
   assign rsp_rdata     = r_rdata;
   assign rsp_err       = r_err;

   assign CPUNC_ARADDR  = w_addr_al;
   assign CPUNC_ARVALID = (r_state == S_AR);
   assign CPUNC_RREADY  = (r_state == S_R);
   assign CPUNC_AWADDR  = w_addr_al;
   assign CPUNC_AWVALID = w_awvalid;
   assign CPUNC_WVALID  = w_wvalid;
   assign CPUNC_WLAST   = w_wvalid;
   assign CPUNC_WDATA   = w_wvalid ? (r_wdata << {w_off, 3'b000}) : '0;
   assign CPUNC_WSTRB   = w_wvalid ? (w_bmask << w_off) : '0;
   assign CPUNC_BREADY  = (r_state == S_B);

endmodule

// File: tb/tb_spike_axi_bridge.sv
// Randomized bench for spike_axi_bridge (DATA_W=32, ADDR_W=12) with a
// reference model computed from byte-lane arithmetic and a reactive slave.
module tb_spike_axi_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 0, req_write = 0;
   logic        req_ready;
   logic [11:0] req_addr = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_wdata = 0;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [11:0] awaddr, araddr;
   logic        awvalid, wvalid, wlast, bready, arvalid, rready;
   logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = 0, rresp = 0;
   logic [31:0] rdata = 0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spike_axi_bridge #(.DATA_W(32), .ADDR_W(12), .TIMEOUT_CYC(255)) dut (
      .CPUNC_ACLK(clk), .CPUNC_ARESET(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .CPUNC_AWADDR(awaddr), .CPUNC_AWVALID(awvalid), .CPUNC_AWREADY(awready),
      .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
      .CPUNC_WVALID(wvalid), .CPUNC_WREADY(wready),
      .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid), .CPUNC_BREADY(bready),
      .CPUNC_ARADDR(araddr), .CPUNC_ARVALID(arvalid), .CPUNC_ARREADY(arready),
      .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RVALID(rvalid),
      .CPUNC_RREADY(rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One request through the bridge with a slave that inserts the given waits.
   task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [1:0] sz,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                          input int aw_d, input int w_d, input int ar_d, input int r_d, input int b_d);
      int nb, off, c, lat, aw_c, w_c, ar_c, r_c, b_c, aw_first, w_first;
      bit chk_err, exp_err, aw_done, w_done, got_rsp, axi_seen, bad_order, bad_drop, bad_last, ar_seen;
      logic [63:0] mask;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_strb;
      logic [11:0] exp_addr;
      nb       = 1 << sz;
      off      = int'(addr) % 4;
      chk_err  = (nb > 4) || ((int'(addr) % nb) != 0);
      exp_err  = chk_err || (resp != 2'b00);
      exp_addr = addr - 12'(off);
      exp_wd   = 32'(64'(wd) << (8 * off));
      exp_strb = 4'(((1 << nb) - 1) << off);
      mask     = (64'd1 << (8 * nb)) - 64'd1;
      exp_rd   = (wr || exp_err) ? 32'd0 : 32'((64'(rd) >> (8 * off)) & mask);
      if (chk_err)  lat = 2;
      else if (wr)  lat = 5 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      else          lat = 4 + ar_d + r_d;
      aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0; aw_first = -1; w_first = -1;
      aw_done = 0; w_done = 0; got_rsp = 0; axi_seen = 0; ar_seen = 0;
      bad_order = 0; bad_drop = 0; bad_last = 0;

      @(negedge clk);
      check_eq("req_ready_idle", req_ready, 1);
      req_valid = 1; req_write = wr; req_addr = addr; req_size = sz; req_wdata = wd;
      @(negedge clk);
      req_valid = 0; req_wdata = $urandom; req_addr = 12'($urandom);
      c = 1;
      while (!got_rsp && c < 300) begin
         if (arvalid || awvalid || wvalid) axi_seen = 1;
         if (bready && !(aw_done && w_done)) bad_order = 1;
         if ((awvalid && aw_done) || (wvalid && w_done)) bad_drop = 1;
         if (wlast !== wvalid) bad_last = 1;
         if (awvalid && aw_first < 0) begin
            aw_first = c;
            check_eq("awaddr", awaddr, exp_addr);
         end
         if (wvalid && w_first < 0) begin
            w_first = c;
            check_eq("wdata", wdata, exp_wd);
            check_eq("wstrb", wstrb, exp_strb);
         end
         if (arvalid && !ar_seen) begin
            ar_seen = 1;
            check_eq("araddr", araddr, exp_addr);
         end
         if (rsp_valid) begin
            got_rsp = 1;
            check_eq("rsp_err", rsp_err, exp_err);
            check_eq("rsp_rdata", rsp_rdata, exp_rd);
            check_eq("rsp_latency", c, lat);
         end
         awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
         rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
         if (awvalid) begin if (aw_c >= aw_d) begin awready = 1; aw_done = 1; end else aw_c++; end
         if (wvalid)  begin if (w_c >= w_d)   begin wready = 1;  w_done = 1;  end else w_c++;  end
         if (arvalid) begin if (ar_c >= ar_d) arready = 1; else ar_c++; end
         if (rready)  begin if (r_c >= r_d) begin rvalid = 1; rdata = rd; rresp = resp; end else r_c++; end
         if (bready)  begin if (b_c >= b_d) begin bvalid = 1; bresp = resp; end else b_c++; end
         @(negedge clk);
         c++;
      end
      awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
      check_eq("rsp_seen", got_rsp, 1);
      check_eq("rsp_one_cycle", rsp_valid, 0);
      check_eq("axi_traffic", axi_seen, !chk_err);
      check_eq("bready_order", bad_order, 0);
      check_eq("valid_drop", bad_drop, 0);
      check_eq("wlast", bad_last, 0);
      if (wr && !chk_err) check_eq("aw_w_same_rise", aw_first, w_first);
   endtask

   initial begin
      bit          wr;
      logic [11:0] a;
      logic [1:0]  sz, rs;
      int          n, kmax;
      bit          got;

      #3;
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_valids", {rsp_valid, awvalid, wvalid, arvalid, rready, bready, wlast}, 0);
      check_eq("rst_data", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_err}, 0);
      @(negedge clk); @(negedge clk);
      rst = 0;
      @(negedge clk);
      check_eq("req_ready_after_rst", req_ready, 1);

      run_txn(1, 12'h013, 2'd0, 32'h000000A5, 32'h0, 2'b00, 0, 0, 0, 0, 0);
      run_txn(0, 12'h006, 2'd1, 32'h0, 32'hBEEF1234, 2'b00, 0, 0, 0, 0, 0);
      run_txn(0, 12'h002, 2'd2, 32'h0, 32'h11111111, 2'b00, 0, 0, 0, 0, 0);
      run_txn(0, 12'h008, 2'd3, 32'h0, 32'h22222222, 2'b00, 0, 0, 0, 0, 0);
      run_txn(1, 12'h040, 2'd2, 32'h12345678, 32'h0, 2'b10, 3, 0, 0, 0, 0);
      run_txn(1, 12'h081, 2'd0, 32'h0000005A, 32'h0, 2'b00, 0, 2, 0, 0, 1);
      run_txn(0, 12'h100, 2'd2, 32'h0, 32'hDEADBEEF, 2'b11, 0, 0, 2, 1, 0);

      for (int t = 0; t < 60; t++) begin
         wr = 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         a  = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) != 0) a = a & ~12'((1 << sz) - 1);
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(wr, a, sz, $urandom, $urandom, rs,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end

`ifdef SPIKE_AXI_TIMEOUT_EN
      @(negedge clk);
      req_valid = 1; req_write = 0; req_addr = 12'h020; req_size = 2'd2;
      @(negedge clk);
      req_valid = 0;
      n = 0; got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (arvalid) n++;
         if (rsp_valid) begin
            got = 1;
            check_eq("tmo_rsp_err", rsp_err, 1);
            check_eq("tmo_rsp_rdata", rsp_rdata, 0);
         end
         @(negedge clk);
      end
      check_eq("tmo_rsp_seen", got, 1);
      check_eq("tmo_ar_cycles", n, 255);
      check_eq("tmo_arvalid_low", arvalid, 0);
`endif

      // reset during the R phase abandons the read
      @(negedge clk);
      req_valid = 1; req_write = 0; req_addr = 12'h030; req_size = 2'd2;
      @(negedge clk);
      req_valid = 0;
      got = 0;
      kmax = 0;
      while (!rready && kmax < 20) begin
         arready = arvalid;
         @(negedge clk);
         kmax++;
      end
      arready = 0;
      check_eq("rst_r_reached", rready, 1);
      rst = 1;
      #1;
      check_eq("rst_rready_drop", rready, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      rst = 0;
      @(negedge clk);
      check_eq("rst_req_ready_first_clk", req_ready, 1);
      for (int k = 0; k < 5; k++) begin
         if (rsp_valid) got = 1;
         @(negedge clk);
      end
      check_eq("rst_no_rsp", got, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
